// File: rtl/float_pkg.sv
// Shared floating-point constants and the normalizer state encoding.
// The rounding stage imports the same widths so both stages agree on the format.
package float_pkg;

    localparam int N_MANT = 24;
    localparam int N_EXP  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/float_normalize_if.sv
// Operand/result handshake bundle between the adder datapath, the normalizer and the rounding stage.
// The driver of raw operands uses master; the normalizer uses slave.
interface float_normalize_if #(
    parameter int n   = 24,
    parameter int exp = 8
);

    logic           inValid;
    logic           inReady;
    logic [n+2:0]   rawMant;
    logic [exp-1:0] rawExp;
    logic           outValid;
    logic           outReady;
    logic [n-1:0]   normMant;
    logic [exp-1:0] normExp;
    logic           R;
    logic           S;
    logic           overflow;
    logic           zero;

    modport master (
        output inValid, rawMant, rawExp, outReady,
        input  inReady, outValid, normMant, normExp, R, S, overflow, zero
    );

    modport slave (
        input  inValid, rawMant, rawExp, outReady,
        output inReady, outValid, normMant, normExp, R, S, overflow, zero
    );

endinterface

// File: rtl/float_normalize.sv
// Iterative post-add normalizer: one right shift for a carry, or one left shift per cycle
// until the hidden bit is set or the exponent bottoms out (denormal).
module float_normalize
    import float_pkg::*;
#(
    parameter int n   = N_MANT,
    parameter int exp = N_EXP
) (
    input logic              Clock,
    input logic              ResetN,
    float_normalize_if.slave bus
);

    localparam logic [exp-1:0] E_ONES = {exp{1'b1}};
    localparam logic [exp-1:0] E_ONE  = {{(exp-1){1'b0}}, 1'b1};
    localparam logic [exp-1:0] E_ZERO = {exp{1'b0}};
    localparam logic [exp-1:0] E_MAX  = E_ONES - E_ONE;
    localparam logic [n+2:0]   W_ZERO = {(n+3){1'b0}};

    state_t         state_r, state_s;
    logic [n+2:0]   w_r, w_s;
    logic [exp-1:0] e_r, e_s;

    logic           in_ready_r, in_ready_s;
    logic           out_valid_r, out_valid_s;
    logic [n-1:0]   norm_mant_r, norm_mant_s;
    logic [exp-1:0] norm_exp_r, norm_exp_s;
    logic           r_bit_r, r_bit_s;
    logic           s_bit_r, s_bit_s;
    logic           overflow_r, overflow_s;
    logic           zero_r, zero_s;

    logic           done_s;
    logic [n+2:0]   res_w_s;
    logic [exp-1:0] res_e_s;
    logic           res_ovf_s;
    logic           res_zero_s;
    logic [n+2:0]   w_shr_s;

    // Next-state, working-register and result-register logic.
    always_comb begin
        state_s     = state_r;
        w_s         = w_r;
        e_s         = e_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        norm_mant_s = norm_mant_r;
        norm_exp_s  = norm_exp_r;
        r_bit_s     = r_bit_r;
        s_bit_s     = s_bit_r;
        overflow_s  = overflow_r;
        zero_s      = zero_r;
        done_s      = 1'b0;
        res_w_s     = w_r;
        res_e_s     = e_r;
        res_ovf_s   = 1'b0;
        res_zero_s  = 1'b0;
        // Carry right shift folds the dropped round bit into sticky.
        w_shr_s     = {1'b0, w_r[n+2:2], w_r[1] | w_r[0]};

        case (state_r)
            IDLE: begin
                if (bus.inValid && in_ready_r) begin
                    w_s        = bus.rawMant;
                    e_s        = bus.rawExp;
                    in_ready_s = 1'b0;
                    state_s    = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (e_r == E_ONES) begin
                    done_s = 1'b1;
                end else if (w_r == W_ZERO) begin
                    done_s     = 1'b1;
                    res_w_s    = W_ZERO;
                    res_e_s    = E_ZERO;
                    res_zero_s = 1'b1;
                end else if (w_r[n+2]) begin
                    if (e_r == E_MAX) begin
                        done_s    = 1'b1;
                        res_w_s   = W_ZERO;
                        res_e_s   = E_ONES;
                        res_ovf_s = 1'b1;
                    end else begin
                        done_s  = 1'b1;
                        w_s     = w_shr_s;
                        e_s     = e_r + E_ONE;
                        res_w_s = w_shr_s;
                        res_e_s = e_r + E_ONE;
                    end
                end else if (w_r[n+1]) begin
                    done_s = 1'b1;
                end else if (e_r <= E_ONE) begin
                    done_s  = 1'b1;
                    res_e_s = E_ZERO;
                end else begin
                    w_s = {w_r[n+1:0], 1'b0};
                    e_s = e_r - E_ONE;
                end

                if (done_s) begin
                    state_s     = DONE;
                    out_valid_s = 1'b1;
                    norm_mant_s = res_w_s[n+1:2];
                    r_bit_s     = res_w_s[1];
                    s_bit_s     = res_w_s[0];
                    norm_exp_s  = res_e_s;
                    overflow_s  = res_ovf_s;
                    zero_s      = res_zero_s;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                out_valid_s = 1'b0;
                in_ready_s  = 1'b1;
            end
        endcase
    end

    // State, working registers and registered outputs; reset forces an idle, empty block.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r     <= IDLE;
            w_r         <= W_ZERO;
            e_r         <= E_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            norm_mant_r <= {n{1'b0}};
            norm_exp_r  <= E_ZERO;
            r_bit_r     <= 1'b0;
            s_bit_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            w_r         <= w_s;
            e_r         <= e_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            norm_mant_r <= norm_mant_s;
            norm_exp_r  <= norm_exp_s;
            r_bit_r     <= r_bit_s;
            s_bit_r     <= s_bit_s;
            overflow_r  <= overflow_s;
            zero_r      <= zero_s;
        end
    end

    assign bus.inReady  = in_ready_r;
    assign bus.outValid = out_valid_r;
    assign bus.normMant = norm_mant_r;
    assign bus.normExp  = norm_exp_r;
    assign bus.R        = r_bit_r;
    assign bus.S        = s_bit_r;
    assign bus.overflow = overflow_r;
    assign bus.zero     = zero_r;

endmodule
